// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch flush controller.
//   state_e        : controller FSM states (IDLE, WAIT, FLUSH)
//   BR_*           : branchControl encodings, identical to the comparator's
//   resolve_taken  : taken decision for a branch type and comparator result
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        FLUSH = 2'b10
    } state_e;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_LT   = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    // Jumps are always taken; conditional branches are taken on any nonzero compare result.
    function automatic logic resolve_taken(input logic [1:0] bc, input logic [1:0] br);
        return (bc == BR_JMP) || (((bc == BR_EQ) || (bc == BR_LT)) && (br != 2'b00));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, clears the count
//   i_inc   : increment request
//   o_count : current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_flush_ctrl.sv
// Branch resolution and IF/ID flush control for the ID stage.
//   clk, rst      : clock, asynchronous active-high reset
//   branchControl : ID-stage branch type (none / BEQ / BLT / JMP)
//   branch        : comparator result, nonzero means taken
//   hazard        : comparator operands not yet valid
//   targetIn      : branch target from ID
//   pcPlus        : sequential PC+1
//   pcNext        : next PC to fetch
//   stall         : hold PC and IF/ID
//   flush         : squash IF/ID
//   busy          : FSM not in IDLE
//   takenCount    : saturating count of taken branches
module branch_flush_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        branchControl,
    input  logic [1:0]        branch,
    input  logic              hazard,
    input  logic [DATA_W-1:0] targetIn,
    input  logic [DATA_W-1:0] pcPlus,
    output logic [DATA_W-1:0] pcNext,
    output logic              stall,
    output logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  takenCount
);

    state_e r_state;
    state_e w_state_nxt;
    logic   w_cond;
    logic   w_taken;
    logic   w_inc;

    assign w_cond  = (branchControl == BR_EQ) || (branchControl == BR_LT);
    assign w_taken = resolve_taken(branchControl, branch);

    always_comb begin
        pcNext      = pcPlus;
        stall       = 1'b0;
        flush       = 1'b0;
        w_inc       = 1'b0;
        w_state_nxt = r_state;

        // Outputs are held inert during reset even though the state is already IDLE.
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (branchControl == BR_NONE) begin
                        w_state_nxt = IDLE;
                    end else if (w_cond && hazard) begin
                        stall       = 1'b1;
                        w_state_nxt = WAIT;
                    end else if (w_taken) begin
                        pcNext      = targetIn;
                        flush       = 1'b1;
                        w_inc       = 1'b1;
                        w_state_nxt = FLUSH;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                WAIT: begin
                    // No timeout: the producer eventually writes back.
                    if (hazard) begin
                        stall       = 1'b1;
                        w_state_nxt = WAIT;
                    end else if (w_taken) begin
                        pcNext      = targetIn;
                        flush       = 1'b1;
                        w_inc       = 1'b1;
                        w_state_nxt = FLUSH;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                FLUSH: begin
                    // Slot behind a taken branch is squashed; its branch fields are ignored.
                    flush       = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign busy = (r_state != IDLE) && !rst;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_taken_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_inc),
        .o_count (takenCount)
    );

endmodule

// File: tb/tb_branch_flush_ctrl.sv
module tb_branch_flush_ctrl;

    localparam int DW   = 16;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    bc;
    logic [1:0]    br;
    logic          hz;
    logic [DW-1:0] tgt;
    logic [DW-1:0] pcp;
    logic [DW-1:0] pcn;
    logic          stall;
    logic          flush;
    logic          busy;
    logic [CW-1:0] cnt;

    int errors = 0;
    int checks = 0;

    // Model: "waiting on hazard", "in squashed slot", number of taken branches.
    bit m_wait  = 1'b0;
    bit m_flush = 1'b0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    branch_flush_ctrl #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .branchControl (bc),
        .branch        (br),
        .hazard        (hz),
        .targetIn      (tgt),
        .pcPlus        (pcp),
        .pcNext        (pcn),
        .stall         (stall),
        .flush         (flush),
        .busy          (busy),
        .takenCount    (cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int rst_v, input int bc_v, input int br_v, input int hz_v,
                         input int tgt_v, input int pcp_v);
        rst = rst_v[0];
        bc  = bc_v[1:0];
        br  = br_v[1:0];
        hz  = hz_v[0];
        tgt = tgt_v[DW-1:0];
        pcp = pcp_v[DW-1:0];
        if (rst_v != 0) begin
            m_wait  = 1'b0;
            m_flush = 1'b0;
            m_cnt   = 0;
        end
        #1;
    endtask

    // Compare DUT against the model mid-cycle, then advance the model across the edge.
    task automatic tick();
        int  e_pc;
        bit  e_st;
        bit  e_fl;
        bit  e_busy;
        bit  n_wait;
        bit  n_flush;
        int  n_cnt;
        bit  cond;
        bit  taken;
        #3;
        e_pc    = int'(pcp);
        e_st    = 1'b0;
        e_fl    = 1'b0;
        e_busy  = (m_wait || m_flush) && !rst;
        n_wait  = 1'b0;
        n_flush = 1'b0;
        n_cnt   = m_cnt;
        cond    = (bc == 2'd1) || (bc == 2'd2);
        taken   = (bc == 2'd3) || (cond && (br != 2'd0));
        if (rst) begin
            n_cnt = 0;
        end else if (m_flush) begin
            e_fl = 1'b1;
        end else if (hz && (m_wait || cond)) begin
            e_st   = 1'b1;
            n_wait = 1'b1;
        end else if (taken) begin
            e_pc    = int'(tgt);
            e_fl    = 1'b1;
            n_flush = 1'b1;
            n_cnt   = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
        check("model_pcNext", int'(pcn), e_pc);
        check("model_stall", int'(stall), int'(e_st));
        check("model_flush", int'(flush), int'(e_fl));
        check("model_busy", int'(busy), int'(e_busy));
        check("model_takenCount", int'(cnt), m_cnt);
        check("model_stall_flush_exclusive", int'(stall & flush), 0);
        @(posedge clk);
        if (!rst) begin
            m_wait  = n_wait;
            m_flush = n_flush;
            m_cnt   = n_cnt;
        end
        #1;
    endtask

    int seq [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b1;
        bc  = 2'd0;
        br  = 2'd0;
        hz  = 1'b0;
        tgt = '0;
        pcp = '0;
        @(posedge clk);
        #1;

        // Reset: a taken-looking branch must not leak through.
        drive(1, 1, 1, 0, 'h0040, 'h0005);
        check("rst_pcNext", int'(pcn), 'h0005);
        check("rst_flush", int'(flush), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(cnt), 0);
        tick();

        // BEQ taken, no hazard: resolves in the same cycle.
        drive(0, 1, 1, 0, 'h0040, 'h0011);
        check("beq_pcNext", int'(pcn), 'h0040);
        check("beq_flush", int'(flush), 1);
        check("beq_stall", int'(stall), 0);
        tick();
        drive(0, 0, 0, 0, 'h0040, 'h0012);
        check("beq_flush2", int'(flush), 1);
        check("beq_busy2", int'(busy), 1);
        check("beq_pc2", int'(pcn), 'h0012);
        tick();
        drive(0, 0, 0, 0, 'h0040, 'h0013);
        check("beq_idle_flush", int'(flush), 0);
        check("beq_idle_busy", int'(busy), 0);
        check("beq_count", int'(cnt), 1);
        tick();

        // BLT under hazard for 3 cycles, then not taken.
        for (int i = 0; i < 3; i++) begin
            drive(0, 2, 0, 1, 'h0300, 'h0020 + i);
            check("blt_stall", int'(stall), 1);
            check("blt_flush", int'(flush), 0);
            check("blt_pc", int'(pcn), 'h0020 + i);
            check("blt_busy", int'(busy), (i == 0) ? 0 : 1);
            tick();
        end
        drive(0, 2, 0, 0, 'h0300, 'h0023);
        check("blt_res_stall", int'(stall), 0);
        check("blt_res_flush", int'(flush), 0);
        check("blt_res_pc", int'(pcn), 'h0023);
        check("blt_res_count", int'(cnt), 1);
        tick();

        // JMP with hazard: taken immediately.
        drive(0, 3, 0, 1, 'h1234, 'h0024);
        check("jmp_pc", int'(pcn), 'h1234);
        check("jmp_stall", int'(stall), 0);
        check("jmp_flush", int'(flush), 1);
        tick();
        // Branch in the squashed slot is ignored.
        drive(0, 1, 1, 0, 'h0099, 'h0025);
        check("sq_flush", int'(flush), 1);
        check("sq_pc", int'(pcn), 'h0025);
        check("sq_count", int'(cnt), 2);
        tick();
        drive(0, 0, 0, 0, 'h0099, 'h0026);
        check("sq_next_busy", int'(busy), 0);
        check("sq_next_count", int'(cnt), 2);
        tick();

        // Saturation with a 2-bit counter.
        drive(1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 2, 0, 'h0100, 'h0030 + i);
            tick();
            drive(0, 0, 0, 0, 'h0100, 'h0040 + i);
            check("sat_count", int'(cnt), seq[i]);
            tick();
        end

        // Reset asserted mid-WAIT.
        drive(0, 2, 0, 1, 'h0500, 'h0050);
        check("w_stall", int'(stall), 1);
        tick();
        drive(0, 2, 0, 1, 'h0500, 'h0051);
        check("w_busy", int'(busy), 1);
        check("w_count", int'(cnt), 3);
        drive(1, 2, 0, 1, 'h0500, 'h0051);
        check("wr_stall", int'(stall), 0);
        check("wr_busy", int'(busy), 0);
        check("wr_count", int'(cnt), 0);
        check("wr_pc", int'(pcn), 'h0051);
        tick();
        drive(0, 0, 0, 0, 'h0500, 'h0077);
        check("post_pc", int'(pcn), 'h0077);
        check("post_busy", int'(busy), 0);
        check("post_stall", int'(stall), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_flush_ctrl.md
BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 16, PC/target width.
REQ-002 The block SHALL provide parameter CNT_W, default 8, taken-branch counter width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-004 branchControl  in  2  ID-stage branch type, same encoding as the comparator: 00 none, 01 BEQ, 10 BLT, 11 JMP (unconditional).
REQ-005 branch  in  2  comparator result for the current branchControl: 00 not taken, any nonzero value taken.
REQ-006 hazard  in  1  Op1 or R15 has a pending non-forwardable write; comparator result invalid.
REQ-007 targetIn  in  DATA_W  branch target computed in ID.
REQ-008 pcPlus  in  DATA_W  sequential PC+1.
REQ-009 pcNext  out  DATA_W  next PC to fetch.
REQ-010 stall  out  1  hold PC and IF/ID this cycle.
REQ-011 flush  out  1  squash IF/ID contents this cycle.
REQ-012 busy  out  1  FSM not in IDLE.
REQ-013 takenCount  out  CNT_W  saturating count of taken branches.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, FLUSH.
REQ-015 "Resolve" SHALL mean: taken = (branchControl==11) or (branchControl in {01,10} and branch!=00).
REQ-016 In IDLE with branchControl==00: pcNext=pcPlus, stall=0, flush=0, stay IDLE.
REQ-017 In IDLE with branchControl==11: resolve as taken in the same cycle; hazard ignored.
REQ-018 In IDLE with branchControl in {01,10} and hazard=1: stall=1, pcNext=pcPlus, flush=0, next state WAIT.
REQ-019 In IDLE or WAIT with branchControl in {01,10} and hazard=0: resolve in the same cycle (zero added latency).
REQ-020 Resolve taken: pcNext=targetIn, flush=1, stall=0, takenCount increments, next state FLUSH.
REQ-021 Resolve not taken: pcNext=pcPlus, flush=0, stall=0, next state IDLE.
REQ-022 In WAIT with hazard=1: stall=1, flush=0, pcNext=pcPlus, stay in WAIT with no timeout.
REQ-023 In FLUSH: flush=1, stall=0, pcNext=pcPlus, branchControl and branch ignored (squashed slot), next state IDLE; a taken branch therefore costs exactly 2 flush cycles.
REQ-024 pcNext, stall and flush SHALL be combinational from state and inputs; state and takenCount SHALL be registered.
REQ-025 takenCount SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 stall and flush SHALL never both be 1 in the same cycle.
REQ-027 busy SHALL be 1 in WAIT and FLUSH, and 0 in IDLE.

Reset
REQ-028 Asserting rst SHALL immediately force state=IDLE and takenCount=0, also when asserted mid-WAIT or mid-FLUSH.
REQ-029 While rst=1: stall=0, flush=0, busy=0, pcNext=pcPlus.
REQ-030 The first edge after rst deassertion SHALL evaluate from IDLE.

Structure
REQ-031 Package branch_ctrl_pkg SHALL hold the state enum (IDLE, WAIT, FLUSH) and the branchControl encodings (BR_NONE, BR_EQ, BR_LT, BR_JMP).
REQ-032 The saturating counter SHALL be one sub-module, sat_counter, parameterised by width.
REQ-033 The comparator SHALL stay outside this block; its branch output connects directly to branch.

Verification
REQ-034 Reset, then branchControl=01, hazard=0, branch=01, targetIn=0x0040: same cycle pcNext=0x0040, flush=1; next cycle flush=1, state FLUSH; then IDLE; takenCount=1.
REQ-035 branchControl=10, hazard=1 for 3 cycles, then hazard=0, branch=00: stall=1 for 3 cycles, then pcNext=pcPlus, flush=0, takenCount unchanged.
REQ-036 branchControl=11, hazard=1, branch=00: taken immediately, pcNext=targetIn, no stall.
REQ-037 In FLUSH, drive branchControl=01, branch=01: ignored; takenCount unchanged, next state IDLE.
REQ-038 With CNT_W=2, 5 taken branches: takenCount sequence 1,2,3,3,3.
REQ-039 Assert rst during WAIT: stall drops immediately, busy=0, takenCount=0; after release, branchControl=00 gives pcNext=pcPlus.
